dice_arbiter: RTL and testbench
===============================

DICE_ARBITER -- requirements
Module: dice_arbiter

Interface
REQ-001 Parameter: ACK_TIMEOUT, default 255, max cycles waited for roll_ack before abort (1..255).
REQ-002 clk  in  1  system clock, all state on rising edge.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 btn1  in  1  player-1 roll request, one-cycle pulse, already debounced.
REQ-005 btn2  in  1  player-2 roll request, one-cycle pulse, already debounced.
REQ-006 roll_req  out  1  request to the shared die generator.
REQ-007 roll_ack  in  1  generator acknowledge; roll_val is valid in the same cycle.
REQ-008 roll_val  in  3  generated die value, legal range 1..6.
REQ-009 dice1  out  3  last accepted value for player 1.
REQ-010 dice2  out  3  last accepted value for player 2.
REQ-011 rolled1  out  1  one-cycle pulse, dice1 updated.
REQ-012 rolled2  out  1  one-cycle pulse, dice2 updated.
REQ-013 busy  out  1  high when state is not IDLE or any request is pending.
REQ-014 err  out  1  one-cycle pulse on timeout or illegal roll_val.
REQ-015 dm_valid  out  1  a Dreimann owner has been assigned.
REQ-016 dm_owner  out  1  Dreimann owner: 0 = player 1, 1 = player 2.
REQ-017 round_cnt  out  8  number of completed rounds, wraps 255 -> 0.

Function
REQ-018 btnX pulse SHALL set pendX; a pulse while pendX is already set is absorbed (no queue depth >1).
REQ-019 Round: each player SHALL be served at most once per round; pendX of a player with doneX=1 SHALL be held, not dropped, until the round closes.
REQ-020 FSM states SHALL be IDLE, REQ, UPDATE; IDLE->REQ when any eligible (pendX & !doneX) request exists; REQ->UPDATE on roll_ack; UPDATE->IDLE unconditionally.
REQ-021 Arbitration in IDLE SHALL be round-robin: if both eligible, grant the player not served last; after reset player 1 wins.
REQ-022 roll_req SHALL rise in the cycle after the IDLE grant decision and stay high until the edge sampling roll_ack=1.
REQ-023 Minimum latency btn pulse -> roll_req SHALL be 2 cycles (pend register, then grant).
REQ-024 At the edge sampling roll_ack=1 with roll_val in 1..6: diceX <= roll_val, doneX <= 1, pendX <= 0, roll_req <= 0; rolledX high for exactly the following cycle.
REQ-025 roll_ack with roll_val 0 or 7: no dice update, err pulse, pendX kept, return to IDLE (retry).
REQ-026 Timeout counter SHALL count cycles in REQ; on reaching ACK_TIMEOUT without ack: roll_req <= 0, err pulse, pendX kept, return to IDLE.
REQ-027 roll_ack outside REQ SHALL be ignored.
REQ-028 Round close SHALL occur in UPDATE when done1 & done2: clear done1/done2, round_cnt +1 (mod 256).
REQ-029 Dreimann rule at round close: exactly one die equal to 3 -> dm_valid <= 1, dm_owner <= that player; both 3 or none -> dm_valid/dm_owner unchanged.
REQ-030 btn pulse coinciding with roll_ack of the same player SHALL register as a new pending request for the next round.

Reset
REQ-031 rst=1 SHALL immediately force: state IDLE, roll_req 0, dice1/dice2 0, rolled1/rolled2 0, err 0, pend/done 0, timeout counter 0, dm_valid 0, dm_owner 0, round_cnt 0, last-served = player 2.
REQ-032 Reset asserted mid-REQ SHALL drop roll_req asynchronously; an ack arriving during reset SHALL be ignored.

Verification
REQ-033 btn1 at cycle 0 -> roll_req high at cycle 2; ack with roll_val=4 at cycle 5 -> dice1=4, rolled1 pulse cycle 6, done1 set.
REQ-034 btn1 and btn2 same cycle after reset -> player 1 served first, then player 2; round_cnt 0->1; dice (3,5) -> dm_valid=1, dm_owner=0.
REQ-035 btn1 twice in one round (second after first served) -> second roll held until player 2 finishes; then served in next round.
REQ-036 ACK_TIMEOUT=4, no ack -> roll_req drops after 4 REQ cycles, err pulse, request retried automatically.
REQ-037 ack with roll_val=7 -> err pulse, dice unchanged, no rolled pulse, retry follows; rst asserted during retry -> all outputs at reset values.

Source files
------------

// File: rtl/dice_arbiter_if.sv
// dice_arbiter_if: bundle between two players, the shared die generator and the dice_arbiter
//   btn1/btn2   : player roll-request pulses
//   roll_req    : request to die generator; roll_ack/roll_val: its answer
//   dice1/dice2 : last accepted values; rolled1/rolled2: update pulses
//   busy, err   : status; dm_valid/dm_owner: Dreimann owner; round_cnt: completed rounds
interface dice_arbiter_if;
    logic       btn1;
    logic       btn2;
    logic       roll_req;
    logic       roll_ack;
    logic [2:0] roll_val;
    logic [2:0] dice1;
    logic [2:0] dice2;
    logic       rolled1;
    logic       rolled2;
    logic       busy;
    logic       err;
    logic       dm_valid;
    logic       dm_owner;
    logic [7:0] round_cnt;
    modport slave (
        input  btn1, btn2, roll_ack, roll_val,
        output roll_req, dice1, dice2, rolled1, rolled2, busy, err, dm_valid, dm_owner, round_cnt
    );
    modport master (
        output btn1, btn2, roll_ack, roll_val,
        input  roll_req, dice1, dice2, rolled1, rolled2, busy, err, dm_valid, dm_owner, round_cnt
    );
endinterface

// File: rtl/dice_arbiter.sv
// dice_arbiter: round-robin sharing of one die generator between two players, with rounds and Dreimann tracking
//   clk : system clock, rst : asynchronous active-high reset
//   bus : dice_arbiter_if.slave (requests in, generator handshake, results and status out)
module dice_arbiter #(
    parameter int ACK_TIMEOUT = 255
) (
    input logic           clk,
    input logic           rst,
    dice_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, UPDATE = 2'd2;
    logic [1:0] r_state;
    logic       r_pend1, r_pend2, r_done1, r_done2;
    logic       r_last, r_grant, r_req;
    logic       r_rolled1, r_rolled2, r_err, r_dm_valid, r_dm_owner;
    logic [2:0] r_dice1, r_dice2;
    logic [7:0] r_tcnt, r_round;
    logic       w_el1, w_el2, w_gnt, w_ok, w_hit, w_tmo, w_srv1, w_srv2, w_close;
    assign w_el1   = r_pend1 & ~r_done1;
    assign w_el2   = r_pend2 & ~r_done2;
    // r_last = 1 means player 2 was served last, so player 1 wins a tie
    assign w_gnt   = (w_el1 & w_el2) ? ~r_last : ~w_el1;
    assign w_hit   = (r_state == REQ) & bus.roll_ack;
    assign w_ok    = (bus.roll_val != 3'd0) & (bus.roll_val != 3'd7);
    assign w_tmo   = (r_state == REQ) & ~bus.roll_ack & (r_tcnt == 8'(ACK_TIMEOUT - 1));
    assign w_srv1  = w_hit & w_ok & ~r_grant;
    assign w_srv2  = w_hit & w_ok & r_grant;
    assign w_close = (r_state == UPDATE) & r_done1 & r_done2;
    assign bus.roll_req  = r_req;
    assign bus.dice1     = r_dice1;
    assign bus.dice2     = r_dice2;
    assign bus.rolled1   = r_rolled1;
    assign bus.rolled2   = r_rolled2;
    assign bus.err       = r_err;
    assign bus.dm_valid  = r_dm_valid;
    assign bus.dm_owner  = r_dm_owner;
    assign bus.round_cnt = r_round;
    assign bus.busy      = (r_state != IDLE) | r_pend1 | r_pend2;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pend1    <= 1'b0;
            r_pend2    <= 1'b0;
            r_done1    <= 1'b0;
            r_done2    <= 1'b0;
            r_last     <= 1'b1;
            r_grant    <= 1'b0;
            r_req      <= 1'b0;
            r_rolled1  <= 1'b0;
            r_rolled2  <= 1'b0;
            r_err      <= 1'b0;
            r_dm_valid <= 1'b0;
            r_dm_owner <= 1'b0;
            r_dice1    <= 3'd0;
            r_dice2    <= 3'd0;
            r_tcnt     <= 8'd0;
            r_round    <= 8'd0;
        end else begin
            // a button pulse on the serving edge re-arms the request for the next round
            r_pend1   <= bus.btn1 | (r_pend1 & ~w_srv1);
            r_pend2   <= bus.btn2 | (r_pend2 & ~w_srv2);
            r_rolled1 <= w_srv1;
            r_rolled2 <= w_srv2;
            r_err     <= (w_hit & ~w_ok) | w_tmo;
            r_done1   <= w_close ? 1'b0 : r_done1 | w_srv1;
            r_done2   <= w_close ? 1'b0 : r_done2 | w_srv2;
            if (w_srv1) r_dice1 <= bus.roll_val;
            if (w_srv2) r_dice2 <= bus.roll_val;
            if (w_hit & w_ok) r_last <= r_grant;
            if (w_close) begin
                r_round <= r_round + 8'd1;
                if ((r_dice1 == 3'd3) ^ (r_dice2 == 3'd3)) begin
                    r_dm_valid <= 1'b1;
                    r_dm_owner <= r_dice2 == 3'd3;
                end
            end
            case (r_state)
                IDLE: if (w_el1 | w_el2) begin
                    r_state <= REQ;
                    r_req   <= 1'b1;
                    r_grant <= w_gnt;
                    r_tcnt  <= 8'd0;
                end
                REQ: if (bus.roll_ack | w_tmo) begin
                    r_req   <= 1'b0;
                    r_state <= (bus.roll_ack & w_ok) ? UPDATE : IDLE;
                end else begin
                    r_tcnt <= r_tcnt + 8'd1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dice_arbiter.sv
// tb_dice_arbiter: directed self-checking bench for dice_arbiter (ACK_TIMEOUT = 4)
module tb_dice_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    dice_arbiter_if dif();
    dice_arbiter #(.ACK_TIMEOUT(4)) dut (.clk(clk), .rst(rst), .bus(dif));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic ack(input logic [2:0] v);
        dif.roll_ack = 1'b1;
        dif.roll_val = v;
        tick();
        dif.roll_ack = 1'b0;
        dif.roll_val = 3'd0;
    endtask
    task automatic chk_rst(input string tag);
        chk({tag, "_req"}, dif.roll_req, 0);
        chk({tag, "_dice1"}, dif.dice1, 0);
        chk({tag, "_dice2"}, dif.dice2, 0);
        chk({tag, "_rolled1"}, dif.rolled1, 0);
        chk({tag, "_rolled2"}, dif.rolled2, 0);
        chk({tag, "_busy"}, dif.busy, 0);
        chk({tag, "_err"}, dif.err, 0);
        chk({tag, "_dmv"}, dif.dm_valid, 0);
        chk({tag, "_dmo"}, dif.dm_owner, 0);
        chk({tag, "_round"}, dif.round_cnt, 0);
    endtask
    initial begin
        dif.btn1 = 1'b0;
        dif.btn2 = 1'b0;
        dif.roll_ack = 1'b0;
        dif.roll_val = 3'd0;
        repeat (2) tick();
        chk_rst("reset");
        rst = 1'b0;
        // single player-1 roll, minimum latency
        tick();
        dif.btn1 = 1'b1;
        tick();
        dif.btn1 = 1'b0;
        chk("lat_c1_req", dif.roll_req, 0);
        chk("lat_c1_busy", dif.busy, 1);
        tick();
        chk("lat_c2_req", dif.roll_req, 1);
        repeat (3) tick();
        chk("c5_req", dif.roll_req, 1);
        ack(3'd4);
        chk("c6_dice1", dif.dice1, 4);
        chk("c6_rolled1", dif.rolled1, 1);
        chk("c6_req", dif.roll_req, 0);
        chk("c6_err", dif.err, 0);
        tick();
        chk("c7_rolled1", dif.rolled1, 0);
        chk("c7_busy", dif.busy, 0);
        // second press by player 1 held until player 2 closes the round
        dif.btn1 = 1'b1;
        tick();
        dif.btn1 = 1'b0;
        chk("held_busy", dif.busy, 1);
        repeat (2) tick();
        chk("held_req", dif.roll_req, 0);
        dif.btn2 = 1'b1;
        tick();
        dif.btn2 = 1'b0;
        tick();
        chk("p2_req", dif.roll_req, 1);
        ack(3'd3);
        chk("p2_rolled2", dif.rolled2, 1);
        chk("p2_dice2", dif.dice2, 3);
        chk("p2_round_pre", dif.round_cnt, 0);
        tick();
        chk("close_round", dif.round_cnt, 1);
        chk("close_dmv", dif.dm_valid, 1);
        chk("close_dmo", dif.dm_owner, 1);
        chk("close_req", dif.roll_req, 0);
        tick();
        chk("next_round_req", dif.roll_req, 1);
        dif.btn1 = 1'b1;
        ack(3'd6);
        dif.btn1 = 1'b0;
        chk("nr_rolled1", dif.rolled1, 1);
        chk("nr_dice1", dif.dice1, 6);
        tick();
        chk("rearm_busy", dif.busy, 1);
        chk("rearm_req", dif.roll_req, 0);
        tick();
        chk("rearm_req2", dif.roll_req, 0);
        // both players in the same cycle after reset
        rst = 1'b1;
        tick();
        chk_rst("reset2");
        rst = 1'b0;
        tick();
        dif.btn1 = 1'b1;
        dif.btn2 = 1'b1;
        tick();
        dif.btn1 = 1'b0;
        dif.btn2 = 1'b0;
        tick();
        chk("both_req1", dif.roll_req, 1);
        ack(3'd3);
        chk("both_rolled1", dif.rolled1, 1);
        chk("both_rolled2_lo", dif.rolled2, 0);
        chk("both_dice1", dif.dice1, 3);
        tick();
        chk("both_gap_req", dif.roll_req, 0);
        tick();
        chk("both_req2", dif.roll_req, 1);
        ack(3'd5);
        chk("both_rolled2", dif.rolled2, 1);
        chk("both_dice2", dif.dice2, 5);
        tick();
        chk("both_round", dif.round_cnt, 1);
        chk("both_dmv", dif.dm_valid, 1);
        chk("both_dmo", dif.dm_owner, 0);
        chk("both_busy", dif.busy, 0);
        // timeout after 4 REQ cycles, then illegal value, then reset mid-retry
        dif.btn1 = 1'b1;
        tick();
        dif.btn1 = 1'b0;
        tick();
        chk("to_req_first", dif.roll_req, 1);
        repeat (3) tick();
        chk("to_req_last", dif.roll_req, 1);
        chk("to_err_lo", dif.err, 0);
        tick();
        chk("to_req_drop", dif.roll_req, 0);
        chk("to_err", dif.err, 1);
        tick();
        chk("to_err_pulse", dif.err, 0);
        chk("to_retry", dif.roll_req, 1);
        ack(3'd7);
        chk("bad_err", dif.err, 1);
        chk("bad_rolled1", dif.rolled1, 0);
        chk("bad_dice1", dif.dice1, 3);
        chk("bad_req", dif.roll_req, 0);
        tick();
        chk("bad_retry", dif.roll_req, 1);
        #2;
        rst = 1'b1;
        dif.roll_ack = 1'b1;
        dif.roll_val = 3'd2;
        #1;
        chk("async_req", dif.roll_req, 0);
        repeat (2) tick();
        chk_rst("rst_hold");
        dif.roll_ack = 1'b0;
        dif.roll_val = 3'd0;
        rst = 1'b0;
        tick();
        chk_rst("post_rst");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
